branch_hazard_ctrl: RTL and testbench

//  Sequences decode-stage branch resolution for the 5-stage MIPS pipeline.
//  - Detects RAW hazards on branch/jr operands and stalls F/D until the operands are valid.
//  - Drives the decode comparator forwarding selects.
//  - Gates the Brancher's PCSrcD so a redirect is issued only on settled operands.
//  - Flushes the wrong-path fetch.

---
 rtl/mips_pkg.sv | 16 +
 rtl/branch_dep_check.sv | 33 +++
 rtl/branch_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch hazard FSM encodings and register constants.
package mips_pkg;

  localparam logic [1:0] BHC_IDLE  = 2'd0;
  localparam logic [1:0] BHC_STALL = 2'd1;
  localparam logic [1:0] BHC_REDIR = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    S_IDLE  = BHC_IDLE,
    S_STALL = BHC_STALL,
    S_REDIR = BHC_REDIR
  } bhc_state_e;

endpackage

// File: rtl/branch_dep_check.sv
// Compares one decode-stage source register against the E and M destinations;
// reports a stall-worthy dependency in E or M and a forwardable ALU result in M.
module branch_dep_check
  import mips_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] srcReg,
  input  logic [REGW-1:0] writeRegE,
  input  logic            regWriteE,
  input  logic [REGW-1:0] writeRegM,
  input  logic            regWriteM,
  input  logic            memtoRegM,
  output logic            hazE,
  output logic            hazM,
  output logic            fwdM
);

  logic notZero;
  logic matchE;
  logic matchM;

  // r0 is hardwired to zero, so it never carries a dependency.
  assign notZero = (srcReg != REGW'(REG_ZERO));
  assign matchE  = notZero && (writeRegE == srcReg);
  assign matchM  = notZero && (writeRegM == srcReg);

  assign hazE = regWriteE & matchE;
  // A load in M has no data until WB, so it must stall rather than forward.
  assign hazM = memtoRegM & regWriteM & matchM;
  assign fwdM = ~memtoRegM & regWriteM & matchM;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencing: RAW stall, comparator forwarding, gated redirect and flush.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REGW       = 5,
  parameter int DELAY_SLOT = 0,
  parameter int MAX_STALL  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            BranchED,
  input  logic            BranchNED,
  input  logic            Branch2RegD,
  input  logic            Branch2ValueD,
  input  logic            PCSrcD,
  input  logic [REGW-1:0] RsD,
  input  logic [REGW-1:0] RtD,
  input  logic [REGW-1:0] WriteRegE,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic [REGW-1:0] WriteRegM,
  input  logic            RegWriteM,
  input  logic            MemtoRegM,
  output logic            ForwardAD,
  output logic            ForwardBD,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushE,
  output logic            FlushD,
  output logic            PCSrcQ,
  output logic            BranchErr,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     BrCount,
  output logic [31:0]     TakenCount,
  output logic [31:0]     StallCount,
`endif
  output logic            ctiD,
  output logic            loadPendingE,
  output logic [1:0]      stateDbg
);

  // The counter must be able to hold MAX_STALL+1 so the overrun is observable.
  localparam int              CNTW    = $clog2(MAX_STALL + 2);
  localparam logic [CNTW-1:0] CNT_SAT = CNTW'(MAX_STALL + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_STALL);
  localparam logic            DS      = (DELAY_SLOT != 0);

  logic useA, useB, bstall;
  logic hazEA, hazMA, fwdA;
  logic hazEB, hazMB, fwdB;

  bhc_state_e      state, stateNext;
  logic [CNTW-1:0] cnt, cntNext;
  logic            errNext;

  branch_dep_check #(.REGW(REGW)) u_depRs (
    .srcReg    (RsD),
    .writeRegE (WriteRegE),
    .regWriteE (RegWriteE),
    .writeRegM (WriteRegM),
    .regWriteM (RegWriteM),
    .memtoRegM (MemtoRegM),
    .hazE      (hazEA),
    .hazM      (hazMA),
    .fwdM      (fwdA)
  );

  branch_dep_check #(.REGW(REGW)) u_depRt (
    .srcReg    (RtD),
    .writeRegE (WriteRegE),
    .regWriteE (RegWriteE),
    .writeRegM (WriteRegM),
    .regWriteM (RegWriteM),
    .memtoRegM (MemtoRegM),
    .hazE      (hazEB),
    .hazM      (hazMB),
    .fwdM      (fwdB)
  );

  // j/jal read no registers, so they take no part in the stall decision.
  assign useA   = BranchED | BranchNED | Branch2RegD;
  assign useB   = BranchED | BranchNED;
  assign bstall = (useA & (hazEA | hazMA)) | (useB & (hazEB | hazMB));

  assign ForwardAD = fwdA;
  assign ForwardBD = fwdB;
  assign StallF    = bstall;
  assign StallD    = bstall;
  assign FlushE    = bstall;
  assign PCSrcQ    = PCSrcD & ~bstall;
  assign FlushD    = PCSrcQ & ~DS;

  assign ctiD         = useA | Branch2ValueD;
  assign loadPendingE = RegWriteE & MemtoRegE;
  assign stateDbg     = state;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      S_IDLE: begin
        if (bstall) begin
          stateNext = S_STALL;
          cntNext   = CNTW'(1);
        end else if (PCSrcQ) begin
          stateNext = S_REDIR;
        end
      end
      S_STALL: begin
        if (bstall) begin
          cntNext = (cnt >= CNT_SAT) ? cnt : cnt + CNTW'(1);
        end else begin
          cntNext   = '0;
          stateNext = PCSrcQ ? S_REDIR : S_IDLE;
        end
      end
      S_REDIR: begin
        // Single-cycle marker; a back-to-back hazarded branch goes straight to STALL.
        if (bstall) begin
          stateNext = S_STALL;
          cntNext   = CNTW'(1);
        end else begin
          stateNext = S_IDLE;
        end
      end
      default: begin
        stateNext = S_IDLE;
        cntNext   = '0;
      end
    endcase
    errNext = BranchErr | (cntNext > CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      BranchErr <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      BranchErr <= errNext;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BrCount    <= '0;
      TakenCount <= '0;
      StallCount <= '0;
    end else begin
      if (ctiD & ~bstall) BrCount <= BrCount + 32'd1;
      if (PCSrcQ)         TakenCount <= TakenCount + 32'd1;
      if (bstall)         StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed scenarios then random stimulus against a rule-level model.
module tb_branch_hazard_ctrl;
  import mips_pkg::*;

  localparam int MAXS = 3;

  logic clk, reset;
  logic BranchED, BranchNED, Branch2RegD, Branch2ValueD, PCSrcD;
  logic [4:0] RsD, RtD, WriteRegE, WriteRegM;
  logic RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;

  logic ForwardAD, ForwardBD, StallF, StallD, FlushE, FlushD, PCSrcQ, BranchErr;
  logic ctiD, loadPendingE;
  logic [1:0] stateDbg;
  logic ds_ForwardAD, ds_ForwardBD, ds_StallF, ds_StallD, ds_FlushE, ds_FlushD, ds_PCSrcQ, ds_BranchErr;
  logic ds_ctiD, ds_loadPendingE;
  logic [1:0] ds_stateDbg;
`ifdef BRANCH_STATS_EN
  logic [31:0] BrCount, TakenCount, StallCount;
  logic [31:0] ds_BrCount, ds_TakenCount, ds_StallCount;
  logic [31:0] m_br, m_taken, m_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  // model state
  int  m_state;
  int  m_run;
  logic m_err;

  branch_hazard_ctrl #(.REGW(5), .DELAY_SLOT(0), .MAX_STALL(MAXS)) u_dut (
    .clk(clk), .reset(reset), .BranchED(BranchED), .BranchNED(BranchNED),
    .Branch2RegD(Branch2RegD), .Branch2ValueD(Branch2ValueD), .PCSrcD(PCSrcD),
    .RsD(RsD), .RtD(RtD), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallF(StallF), .StallD(StallD),
    .FlushE(FlushE), .FlushD(FlushD), .PCSrcQ(PCSrcQ), .BranchErr(BranchErr),
`ifdef BRANCH_STATS_EN
    .BrCount(BrCount), .TakenCount(TakenCount), .StallCount(StallCount),
`endif
    .ctiD(ctiD), .loadPendingE(loadPendingE), .stateDbg(stateDbg)
  );

  branch_hazard_ctrl #(.REGW(5), .DELAY_SLOT(1), .MAX_STALL(MAXS)) u_ds (
    .clk(clk), .reset(reset), .BranchED(BranchED), .BranchNED(BranchNED),
    .Branch2RegD(Branch2RegD), .Branch2ValueD(Branch2ValueD), .PCSrcD(PCSrcD),
    .RsD(RsD), .RtD(RtD), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .ForwardAD(ds_ForwardAD), .ForwardBD(ds_ForwardBD), .StallF(ds_StallF), .StallD(ds_StallD),
    .FlushE(ds_FlushE), .FlushD(ds_FlushD), .PCSrcQ(ds_PCSrcQ), .BranchErr(ds_BranchErr),
`ifdef BRANCH_STATS_EN
    .BrCount(ds_BrCount), .TakenCount(ds_TakenCount), .StallCount(ds_StallCount),
`endif
    .ctiD(ds_ctiD), .loadPendingE(ds_loadPendingE), .stateDbg(ds_stateDbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference rules
  function automatic logic hz_e(input logic [4:0] r);
    return RegWriteE && (WriteRegE == r) && (r != 0);
  endfunction
  function automatic logic hz_m(input logic [4:0] r);
    return MemtoRegM && RegWriteM && (WriteRegM == r) && (r != 0);
  endfunction
  function automatic logic fw_m(input logic [4:0] r);
    return (r != 0) && RegWriteM && !MemtoRegM && (WriteRegM == r);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_run   = 0;
    m_err   = 1'b0;
`ifdef BRANCH_STATS_EN
    m_br = 0; m_taken = 0; m_stall = 0;
`endif
  endtask

  task automatic clear_inputs();
    BranchED = 0; BranchNED = 0; Branch2RegD = 0; Branch2ValueD = 0; PCSrcD = 0;
    RsD = 0; RtD = 0; WriteRegE = 0; RegWriteE = 0; MemtoRegE = 0;
    WriteRegM = 0; RegWriteM = 0; MemtoRegM = 0;
  endtask

  // driver: called just after a rising edge with inputs already applied
  task automatic step(input string tag);
    logic useA, useB, bs, q;
    useA = BranchED | BranchNED | Branch2RegD;
    useB = BranchED | BranchNED;
    bs = (useA && (hz_e(RsD) || hz_m(RsD))) || (useB && (hz_e(RtD) || hz_m(RtD)));
    q  = PCSrcD && !bs;
    #3;
    chk({tag, ".stallF"}, 32'(StallF), 32'(bs));
    chk({tag, ".stallD"}, 32'(StallD), 32'(bs));
    chk({tag, ".flushE"}, 32'(FlushE), 32'(bs));
    chk({tag, ".fwdA"},   32'(ForwardAD), 32'(fw_m(RsD)));
    chk({tag, ".fwdB"},   32'(ForwardBD), 32'(fw_m(RtD)));
    chk({tag, ".pcsrcq"}, 32'(PCSrcQ), 32'(q));
    chk({tag, ".flushD"}, 32'(FlushD), 32'(q));
    chk({tag, ".ds_flushD"}, 32'(ds_FlushD), 32'd0);
    chk({tag, ".ds_pcsrcq"}, 32'(ds_PCSrcQ), 32'(q));
    chk({tag, ".cti"}, 32'(ctiD), 32'(useA | Branch2ValueD));
    chk({tag, ".ldE"}, 32'(loadPendingE), 32'(RegWriteE & MemtoRegE));
    if (!reset) begin
      if (bs) begin
        m_run = (m_run >= MAXS + 1) ? m_run : m_run + 1;
        if (m_run > MAXS) m_err = 1'b1;
        m_state = 1;
      end else begin
        m_run = 0;
        m_state = (q && m_state != 2) ? 2 : 0;
      end
`ifdef BRANCH_STATS_EN
      if ((useA | Branch2ValueD) && !bs) m_br++;
      if (q) m_taken++;
      if (bs) m_stall++;
`endif
    end
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 32'(stateDbg), 32'(m_state));
    chk({tag, ".err"},   32'(BranchErr), 32'(m_err));
    chk({tag, ".ds_err"}, 32'(ds_BranchErr), 32'(m_err));
`ifdef BRANCH_STATS_EN
    chk({tag, ".brCnt"},    BrCount, m_br);
    chk({tag, ".takenCnt"}, TakenCount, m_taken);
    chk({tag, ".stallCnt"}, StallCount, m_stall);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset.state", 32'(stateDbg), 32'(BHC_IDLE));
    chk("reset.err", 32'(BranchErr), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #1;
    do_reset();

`ifdef BRANCH_STATS_EN
    // three branches, two taken, one stall cycle
    BranchED = 1; RsD = 5'd1; RtD = 5'd2; PCSrcD = 1; step("stats.beq_taken");
    clear_inputs(); BranchNED = 1; RsD = 5'd3; RtD = 5'd4; RegWriteE = 1; WriteRegE = 5'd4; PCSrcD = 1;
    step("stats.bne_stall");
    RegWriteE = 0; step("stats.bne_taken");
    clear_inputs(); BranchED = 1; RsD = 5'd5; RtD = 5'd6; step("stats.beq_not");
    clear_inputs();
    chk("stats.br3", BrCount, 32'd3);
    chk("stats.taken2", TakenCount, 32'd2);
    chk("stats.stall1", StallCount, 32'd1);
    do_reset();
`endif

    // beq with ALU producer in E: one stall cycle, then clear
    BranchED = 1; RsD = 5'd8; RtD = 5'd9; RegWriteE = 1; WriteRegE = 5'd8; PCSrcD = 1;
    step("beq_hazE");
    chk("beq_hazE.stalled", 32'(stateDbg), 32'(BHC_STALL));
    RegWriteE = 0; PCSrcD = 0;
    step("beq_hazE_clear");
    chk("beq_hazE.idle", 32'(stateDbg), 32'(BHC_IDLE));

    // beq with a load in M: stall, then redirect with flush and no forward
    clear_inputs(); BranchED = 1; RsD = 5'd8; RtD = 5'd9;
    RegWriteM = 1; MemtoRegM = 1; WriteRegM = 5'd8; PCSrcD = 1;
    step("beq_lwM");
    RegWriteM = 0; MemtoRegM = 0;
    #3;
    chk("beq_lwM.q", 32'(PCSrcQ), 32'd1);
    chk("beq_lwM.flushD", 32'(FlushD), 32'd1);
    chk("beq_lwM.fwdA", 32'(ForwardAD), 32'd0);
    #(-0);
    @(negedge clk);
    @(posedge clk); #1;
    m_run = 0; m_state = 2;
    chk("beq_lwM.redir", 32'(stateDbg), 32'(BHC_REDIR));

    // bne forwarded from M: no stall, redirect
    clear_inputs(); BranchNED = 1; RsD = 5'd3; RtD = 5'd10;
    RegWriteM = 1; WriteRegM = 5'd10; PCSrcD = 1;
    step("bne_fwdB");

    // jr on r0 and j with hazards never stall
    clear_inputs(); Branch2RegD = 1; RsD = 5'd0; RegWriteE = 1; WriteRegE = 5'd0;
    step("jr_r0");
    clear_inputs(); Branch2ValueD = 1; RsD = 5'd7; RtD = 5'd7; RegWriteE = 1; WriteRegE = 5'd7;
    RegWriteM = 1; MemtoRegM = 1; WriteRegM = 5'd7; PCSrcD = 1;
    step("j_haz");

    // stall budget overrun, then async reset mid-stall
    clear_inputs(); step("pre_budget");
    BranchED = 1; RsD = 5'd12; RegWriteE = 1; WriteRegE = 5'd12;
    for (int i = 0; i < 5; i++) step($sformatf("budget%0d", i));
    #3;
    reset = 1'b1;
    #1;
    chk("midstall.state", 32'(stateDbg), 32'(BHC_IDLE));
    chk("midstall.err", 32'(BranchErr), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      {BranchED, BranchNED, Branch2RegD, Branch2ValueD} = 4'(1 << $urandom_range(0, 4));
      PCSrcD    = 1'($urandom_range(0, 1));
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      MemtoRegM = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($sformatf("rnd%0d", n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
